shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register driven by push-button requests: it loads, shifts, rotates, presents the word in parallel, and bursts it out serially. Buttons are asynchronous board inputs; each press is synchronised, edge-detected and executed exactly once. Sits between the board switch/button inputs and the LED/serial output logic of the lab top level.

## Interface
- WIDTH, 16, register width in bits; legal range 2..64
- MSB_FIRST, 0, serial burst order; 0 = bit 0 first, 1 = bit WIDTH-1 first
- clk  in  1  single clock; every flop is on its rising edge
- _rst  in  1  reset, asynchronous and active-low; clears every flop
- D  in  WIDTH  parallel load data, sampled directly (held stable by the user)
- ser_in  in  1  fill bit for logical shifts, sampled directly
- btn  in  7  async request buttons, active-high: [0] load, [1] out_par, [2] out_pos, [3] shl, [4] shr, [5] rotl, [6] rotr
- Q_par  out  WIDTH  parallel output snapshot
- Q_pos  out  1  serial output bit
- busy  out  1  serial burst in progress
- done  out  1  one-cycle pulse after the last serial bit
- err  out  1  one-cycle pulse: request rejected

## Operation
- Each btn bit passes through a 2-flop synchroniser, then a previous-value flop; req[i] = sync2[i] & ~prev[i] (rising edge, one cycle wide).
- Internal register R[WIDTH-1:0]; ops executed in state IDLE on the cycle req is valid:
  - load: R <= D
  - out_par: Q_par <= R (Q_par holds until the next out_par or reset)
  - shl: R <= {R[WIDTH-2:0], ser_in}; shr: R <= {ser_in, R[WIDTH-1:1]}
  - rotl: R <= {R[WIDTH-2:0], R[WIDTH-1]}; rotr: R <= {R[0], R[WIDTH-1:1]}
  - out_pos: S <= R, cnt <= 0, state -> SEND
- More than one req bit high in the same cycle: no operation, err pulses.
- Any req while state = SEND: ignored, err pulses; R, Q_par unchanged.
- FSM states: IDLE, SEND, DONE.
  - IDLE -> SEND on a lone out_pos req.
  - SEND: Q_pos = S[0] (MSB_FIRST=0) or S[WIDTH-1] (MSB_FIRST=1); each cycle S shifts toward the output end by 1, cnt increments; when cnt = WIDTH-1, next state DONE.
  - DONE: done = 1 for one cycle, Q_pos = 0, busy = 0; always -> IDLE.
- busy = 1 exactly while in SEND. Q_pos = 0 outside SEND.
- cnt is $clog2(WIDTH) bits; no wrap beyond WIDTH-1.
- R is never altered by a serial burst; the burst transmits the value R held on the request cycle.
- Holding a button produces one op; release and re-press produce another.

## Timing
- Reset (async assert, any time, including mid-burst): R = 0, S = 0, Q_par = 0, Q_pos = 0, busy = 0, done = 0, err = 0, state IDLE, sync/prev flops = 0; no done pulse for an aborted burst.
- First release of _rst: sync flops start at 0, so a button already held at reset release counts as one press.
- Request latency: btn first sampled high at edge k -> req valid after edge k+1 -> R/Q_par update (or SEND entry) at edge k+2.
- Serial burst: busy rises at edge k+2 and stays high for exactly WIDTH cycles; bit j valid on Q_pos in cycle j of SEND; done high for the single cycle after the last bit; a new out_pos is accepted from the IDLE cycle after DONE.
- err is registered: high for the one cycle after the rejected req cycle.
- All outputs registered except none combinational from btn; Q_pos, busy, done decoded from registered state and S.

## Test plan
- Reset mid-burst: load 16'hA5C3, start out_pos, assert _rst after 5 bits -> all outputs 0 immediately, no done, R = 0.
- Load/out_par: D = 16'hA5C3, press load then out_par -> Q_par = 16'hA5C3 at edge 2 after out_par sync; Q_par unchanged by later shl.
- Shifts/rotates: R = 16'h8001; rotl -> 16'h0003; rotr twice -> 16'hC000; shl with ser_in=1 -> 16'h8001; shr with ser_in=0 -> 16'h4000.
- Serial burst, MSB_FIRST=0, R = 16'hA5C3: Q_pos sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; busy high 16 cycles; done one cycle; repeat with MSB_FIRST=1 -> reversed order.
- Conflicts: shl and rotr pressed same cycle -> err one pulse, R unchanged; load pressed during SEND -> err, R unchanged, burst completes.
- Button held 50 cycles with rotl -> exactly one rotation; WIDTH=2 build: rotl on 2'b01 -> 2'b10, burst of 2 bits then done.

Source files
------------

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_univ
// Brief    : Universal shift register driven by push-button requests. Each
//            button is synchronised and edge-detected, so one press runs one
//            operation: load, parallel snapshot, logical shift, rotate, or
//            a serial burst of the register contents.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
  parameter int WIDTH     = 16,  // register width, 2..64
  parameter int MSB_FIRST = 0    // 0: bit 0 leaves first, 1: bit WIDTH-1 first
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in,
  input  logic [6:0]       btn,
  output logic [WIDTH-1:0] Q_par,
  output logic             Q_pos,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  // Button bit positions
  localparam int c_OP_LOAD    = 0;
  localparam int c_OP_OUT_PAR = 1;
  localparam int c_OP_OUT_POS = 2;
  localparam int c_OP_SHL     = 3;
  localparam int c_OP_SHR     = 4;
  localparam int c_OP_ROTL    = 5;
  localparam int c_OP_ROTR    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [6:0]         r_sync1;
  logic [6:0]         r_sync2;
  logic [6:0]         r_prev;
  logic [6:0]         w_req;
  logic               w_any;
  logic               w_multi;
  logic               w_lone;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_reg;
  logic [WIDTH-1:0]   w_reg_nxt;
  logic [WIDTH-1:0]   r_qpar;
  logic [WIDTH-1:0]   w_qpar_nxt;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   w_s_nxt;
  logic [WIDTH-1:0]   w_s_shifted;
  logic               w_out_bit;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_err;
  logic               w_err_nxt;

  // --------------------------------------------------------------------------
  // Button synchronisation and rising-edge detection
  // --------------------------------------------------------------------------
  // Two-flop synchroniser followed by a previous-value flop per button.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // A request is the first synchronised-high cycle of a press. Clearing the
  // lowest set bit leaves something only when two or more requests coincide.
  assign w_req   = r_sync2 & ~r_prev;
  assign w_any   = |w_req;
  assign w_multi = |(w_req & (w_req - 7'd1));
  assign w_lone  = w_any & ~w_multi;

  // --------------------------------------------------------------------------
  // Serial output ordering
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_out_bit   = r_s[WIDTH-1];
      assign w_s_shifted = {r_s[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit   = r_s[0];
      assign w_s_shifted = {1'b0, r_s[WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Burst state machine
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a lone out_pos request starts a burst of WIDTH cycles, then
  // a single DONE cycle before returning to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_lone && w_req[c_OP_OUT_POS]) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  // Operations run only in IDLE with exactly one request; anything else that
  // arrives is rejected with an err pulse. The burst works on its own copy S
  // so the working register R is never disturbed by serialisation.
  always_comb begin
    w_reg_nxt  = r_reg;
    w_qpar_nxt = r_qpar;
    w_s_nxt    = r_s;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = 1'b0;

    if (r_state == ST_SEND) begin
      w_s_nxt = w_s_shifted;
      if (r_cnt != c_CNT_LAST) begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
      end
    end

    if (r_state != ST_IDLE) begin
      w_err_nxt = w_any;
    end else if (w_multi) begin
      w_err_nxt = 1'b1;
    end else if (w_lone) begin
      if (w_req[c_OP_LOAD]) begin
        w_reg_nxt = D;
      end
      if (w_req[c_OP_OUT_PAR]) begin
        w_qpar_nxt = r_reg;
      end
      if (w_req[c_OP_OUT_POS]) begin
        w_s_nxt   = r_reg;
        w_cnt_nxt = '0;
      end
      if (w_req[c_OP_SHL]) begin
        w_reg_nxt = {r_reg[WIDTH-2:0], ser_in};
      end
      if (w_req[c_OP_SHR]) begin
        w_reg_nxt = {ser_in, r_reg[WIDTH-1:1]};
      end
      if (w_req[c_OP_ROTL]) begin
        w_reg_nxt = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
      end
      if (w_req[c_OP_ROTR]) begin
        w_reg_nxt = {r_reg[0], r_reg[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_reg  <= '0;
      r_qpar <= '0;
      r_s    <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_reg  <= w_reg_nxt;
      r_qpar <= w_qpar_nxt;
      r_s    <= w_s_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // --------------------------------------------------------------------------
  assign busy  = (r_state == ST_SEND);
  assign done  = (r_state == ST_DONE);
  assign Q_pos = busy & w_out_bit;
  assign Q_par = r_qpar;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_univ
// Brief    : Self-checking bench for shift_reg_univ: LSB-first and MSB-first
//            16-bit instances sharing stimulus, plus a 2-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_univ;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [W-1:0] d     = '0;
  logic         ser   = 1'b0;
  logic [6:0]   btn   = '0;
  logic [1:0]   d2    = '0;
  logic         ser2  = 1'b0;
  logic [6:0]   btn2  = '0;

  logic [W-1:0] qpar_l, qpar_m;
  logic         qpos_l, qpos_m, busy_l, busy_m, done_l, done_m, err_l, err_m;
  logic [1:0]   qpar2;
  logic         qpos2, busy2, done2, err2;

  shift_reg_univ #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), ._rst(rst_n), .D(d), .ser_in(ser), .btn(btn),
    .Q_par(qpar_l), .Q_pos(qpos_l), .busy(busy_l), .done(done_l), .err(err_l)
  );

  shift_reg_univ #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), ._rst(rst_n), .D(d), .ser_in(ser), .btn(btn),
    .Q_par(qpar_m), .Q_pos(qpos_m), .busy(busy_m), .done(done_m), .err(err_m)
  );

  shift_reg_univ #(.WIDTH(2), .MSB_FIRST(0)) dut_w2 (
    .clk(clk), ._rst(rst_n), .D(d2), .ser_in(ser2), .btn(btn2),
    .Q_par(qpar2), .Q_pos(qpos2), .busy(busy2), .done(done2), .err(err2)
  );

  localparam logic [6:0] OP_LOAD = 7'h01, OP_PAR = 7'h02, OP_POS = 7'h04,
                         OP_SHL  = 7'h08, OP_SHR = 7'h10, OP_ROTL = 7'h20,
                         OP_ROTR = 7'h40;

  typedef struct {
    logic [6:0]   op;
    logic [W-1:0] din;
    logic         sin;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t        tbl[10];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] par_q[$];
  logic        bit_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold a button mask for 'hold' cycles, release, let the pipeline settle.
  task automatic press(input logic [6:0] mask, input int hold);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic press2(input logic [6:0] mask);
    btn2 = mask;
    repeat (2) @(negedge clk);
    btn2 = '0;
    repeat (5) @(negedge clk);
  endtask

  // Snapshot R through out_par and compare against the queued expectation.
  task automatic check_par(input string name, input logic [W-1:0] exp);
    logic [63:0] e;
    par_q.push_back(64'(exp));
    press(OP_PAR, 2);
    e = par_q.pop_front();
    check({name, "_lsb"}, 64'(qpar_l), e);
    check({name, "_msb"}, 64'(qpar_m), e);
  endtask

  // Serial burst of 'val' on both 16-bit instances; optionally press load
  // in the middle of the burst and expect it to be rejected.
  task automatic burst(input logic [W-1:0] val, input bit inject);
    logic b;
    for (int j = 0; j < W; j++) bit_q.push_back(val[j]);
    btn = OP_POS;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    check("busy_before", 64'(busy_l), 64'd0);
    @(negedge clk);
    for (int j = 0; j < W; j++) begin
      if (j > 0) @(negedge clk);
      b = bit_q.pop_front();
      check($sformatf("busy_l_%0d", j), 64'(busy_l), 64'd1);
      check($sformatf("busy_m_%0d", j), 64'(busy_m), 64'd1);
      check($sformatf("qpos_l_%0d", j), 64'(qpos_l), 64'(b));
      check($sformatf("qpos_m_%0d", j), 64'(qpos_m), 64'(val[W-1-j]));
      check($sformatf("done_%0d", j), 64'(done_l), 64'd0);
      if (inject) begin
        if (j == 3) begin d = 16'h1234; btn = OP_LOAD; end
        if (j == 5) begin
          btn = '0;
          check("err_early", 64'(err_l), 64'd0);
        end
        if (j == 6) check("err_in_send", 64'(err_l), 64'd1);
        if (j == 7) check("err_one_cycle", 64'(err_l), 64'd0);
      end
    end
    @(negedge clk);
    check("done_l", 64'(done_l), 64'd1);
    check("done_m", 64'(done_m), 64'd1);
    check("busy_in_done", 64'(busy_l), 64'd0);
    check("qpos_in_done", 64'(qpos_l), 64'd0);
    @(negedge clk);
    check("done_cleared", 64'(done_l), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{OP_LOAD, 16'h8001, 1'b0, 16'h8001, "load_8001"};
    tbl[1] = '{OP_ROTL, 16'h0000, 1'b0, 16'h0003, "rotl"};
    tbl[2] = '{OP_ROTR, 16'h0000, 1'b0, 16'h8001, "rotr_1"};
    tbl[3] = '{OP_ROTR, 16'h0000, 1'b0, 16'hC000, "rotr_2"};
    tbl[4] = '{OP_SHL,  16'h0000, 1'b1, 16'h8001, "shl_in1"};
    tbl[5] = '{OP_SHR,  16'h0000, 1'b0, 16'h4000, "shr_in0"};
    tbl[6] = '{OP_LOAD, 16'hA5C3, 1'b0, 16'hA5C3, "load_a5c3"};
    tbl[7] = '{OP_SHR,  16'h0000, 1'b1, 16'hD2E1, "shr_in1"};
    tbl[8] = '{OP_ROTL, 16'h0000, 1'b0, 16'hA5C3, "rotl_2"};
    tbl[9] = '{OP_SHL,  16'h0000, 1'b0, 16'h4B86, "shl_in0"};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_qpar", 64'(qpar_l), 64'd0);
    check("rst_busy", 64'(busy_l), 64'd0);
    check("rst_done", 64'(done_l), 64'd0);
    check("rst_err",  64'(err_l),  64'd0);
    check("rst_qpos", 64'(qpos_l), 64'd0);
    check("rst_w2",   64'(qpar2),  64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      d   = tbl[i].din;
      ser = tbl[i].sin;
      press(tbl[i].op, 2);
      check_par(tbl[i].name, tbl[i].exp);
    end

    // out_par latency and hold
    d = 16'hA5C3;
    press(OP_LOAD, 2);
    btn = OP_PAR;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    check("qpar_not_yet", 64'(qpar_l), 64'h4B86);
    @(negedge clk);
    check("qpar_edge2", 64'(qpar_l), 64'hA5C3);
    repeat (3) @(negedge clk);
    ser = 1'b0;
    press(OP_SHL, 2);
    check("qpar_held", 64'(qpar_l), 64'hA5C3);
    press(OP_LOAD, 2);

    // Clean burst, then burst with a rejected load in the middle
    burst(16'hA5C3, 1'b0);
    burst(16'hA5C3, 1'b1);
    d = 16'hA5C3;
    check_par("r_after_burst", 16'hA5C3);

    // Two requests in the same cycle
    btn = OP_SHL | OP_ROTR;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    check("conf_err_pre", 64'(err_l), 64'd0);
    @(negedge clk);
    check("conf_err", 64'(err_l), 64'd1);
    @(negedge clk);
    check("conf_err_clr", 64'(err_l), 64'd0);
    repeat (3) @(negedge clk);
    check_par("conf_r", 16'hA5C3);

    // Held button: exactly one rotation
    press(OP_ROTL, 50);
    check_par("held_rotl", 16'h4B87);

    // 2-bit instance
    d2 = 2'b01;
    press2(OP_LOAD);
    press2(OP_ROTL);
    press2(OP_PAR);
    check("w2_rotl", 64'(qpar2), 64'd2);
    btn2 = OP_POS;
    @(negedge clk);
    btn2 = '0;
    repeat (2) @(negedge clk);
    check("w2_busy0", 64'(busy2), 64'd1);
    check("w2_bit0",  64'(qpos2), 64'd0);
    @(negedge clk);
    check("w2_busy1", 64'(busy2), 64'd1);
    check("w2_bit1",  64'(qpos2), 64'd1);
    @(negedge clk);
    check("w2_done",  64'(done2), 64'd1);
    check("w2_idle",  64'(busy2), 64'd0);
    @(negedge clk);
    check("w2_done_clr", 64'(done2), 64'd0);

    // Reset in the middle of a burst
    d = 16'hA5C3;
    press(OP_LOAD, 2);
    btn = OP_POS;
    @(negedge clk);
    btn = '0;
    repeat (7) @(negedge clk);
    check("mid_busy_pre", 64'(busy_l), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 64'(busy_l), 64'd0);
    check("mid_qpos", 64'(qpos_l), 64'd0);
    check("mid_qpar", 64'(qpar_l), 64'd0);
    check("mid_done", 64'(done_l), 64'd0);
    check("mid_err",  64'(err_l),  64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_done", 64'(done_l), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_par("mid_r_zero", 16'h0000);

    // Button held across reset release counts as one press
    rst_n = 1'b0;
    d     = 16'h00F0;
    btn   = OP_LOAD;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (5) @(negedge clk);
    check_par("held_at_release", 16'h00F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
